// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmit stage.
// Captures each byte the receiver stage presents, queues it in a small FIFO
// and serialises it LSB first onto TX. Frames are 8N1, or 8E1 when the
// UART_TX_PARITY_EN macro is defined. Bit timing counts ENABLE ticks.
//
// Parameters:
//   BIT_TICKS  (2..63)          ENABLE ticks per transmitted bit
//   FIFO_DEPTH (pow2, 2..16)    byte queue depth
// Ports:
//   clk                      system clock, rising edge
//   res                      synchronous active-high reset
//   ENABLE                   bit-timing tick; FSM and counters freeze when low
//   CONECT_PRIZNAC           receiver byte-valid level
//   word_receiver[7:0]       received byte
//   TX                       serial line, idle high
//   priznak_end_transmitter  one-clk pulse after each frame's final stop tick
//   busy                     frame in progress
//   fifo_full                queue holds FIFO_DEPTH bytes
//   overflow                 sticky: a byte was dropped on a full queue
module uart_tx_frame #(
  parameter int unsigned BIT_TICKS  = 5,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       res,
  input  logic       ENABLE,
  input  logic       CONECT_PRIZNAC,
  input  logic [7:0] word_receiver,
  output logic       TX,
  output logic       priznak_end_transmitter,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [5:0]    TICK_LAST = 6'(BIT_TICKS - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PAR,
`endif
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [5:0]      tick_q, tick_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            taken_q;
  logic            tx_q, tx_d;
  logic            end_q, end_d;
  logic            busy_q;
  logic            full_q;
  logic            ovf_q, ovf_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  logic       empty, last_tick, push_req, push, pop;
  logic [7:0] head;

  assign empty     = (count_q == '0);
  assign last_tick = (tick_q == TICK_LAST);
  assign head      = mem_q[rd_ptr_q];
  assign push_req  = CONECT_PRIZNAC && !taken_q;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    end_d   = 1'b0;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (ENABLE) begin
      case (state_q)
        S_IDLE: begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
`ifdef UART_TX_PARITY_EN
            par_d   = ^head;
`endif
            tick_d  = '0;
            state_d = S_START;
          end
        end
        S_START: begin
          if (last_tick) begin
            tick_d  = '0;
            idx_d   = '0;
            state_d = S_DATA;
          end else begin
            tick_d = tick_q + 6'd1;
          end
        end
        S_DATA: begin
          if (last_tick) begin
            tick_d  = '0;
            shift_d = {1'b0, shift_q[7:1]};
            idx_d   = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_d = S_PAR;
`else
              state_d = S_STOP;
`endif
            end
          end else begin
            tick_d = tick_q + 6'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PAR: begin
          if (last_tick) begin
            tick_d  = '0;
            state_d = S_STOP;
          end else begin
            tick_d = tick_q + 6'd1;
          end
        end
`endif
        S_STOP: begin
          if (last_tick) begin
            tick_d = '0;
            end_d  = 1'b1;
            // Pending byte chains straight into the next start bit.
            if (!empty) begin
              pop     = 1'b1;
              shift_d = head;
`ifdef UART_TX_PARITY_EN
              par_d   = ^head;
`endif
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tick_d = tick_q + 6'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // A same-cycle pop frees a slot, so a push on a full queue still lands.
    push  = push_req && ((count_q != CNT_FULL) || pop);
    ovf_d = ovf_q || (push_req && !push);

    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    // TX is registered from the next state so it changes on the tick edge.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PAR:   tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q  <= S_IDLE;
      tick_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      taken_q  <= 1'b0;
      tx_q     <= 1'b1;
      end_q    <= 1'b0;
      busy_q   <= 1'b0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      count_q <= count_d;
      taken_q <= CONECT_PRIZNAC;
      tx_q    <= tx_d;
      end_q   <= end_d;
      busy_q  <= (state_d != S_IDLE);
      full_q  <= (count_d == CNT_FULL);
      ovf_q   <= ovf_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= word_receiver;
  end

  assign TX                      = tx_q;
  assign priznak_end_transmitter = end_q;
  assign busy                    = busy_q;
  assign fifo_full               = full_q;
  assign overflow                = ovf_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
module tb_uart_tx_frame;

  localparam int unsigned BT = 5;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       ENABLE = 1'b0;
  logic       CONECT_PRIZNAC = 1'b0;
  logic [7:0] word_receiver = 8'h00;
  logic       TX, priznak_end_transmitter, busy, fifo_full, overflow;

  uart_tx_frame #(.BIT_TICKS(BT), .FIFO_DEPTH(4)) dut (
    .clk                     (clk),
    .res                     (res),
    .ENABLE                  (ENABLE),
    .CONECT_PRIZNAC          (CONECT_PRIZNAC),
    .word_receiver           (word_receiver),
    .TX                      (TX),
    .priznak_end_transmitter (priznak_end_transmitter),
    .busy                    (busy),
    .fifo_full               (fifo_full),
    .overflow                (overflow)
  );

  always #5 clk = ~clk;

  // ENABLE generator: high one cycle in en_period, held low when 0.
  int en_period = 0;
  int cyc = 0;
  always @(negedge clk) begin
    cyc = cyc + 1;
    ENABLE = (en_period != 0) && ((cyc % en_period) == 0);
  end

  // frame[i] is the i-th line bit sent: start, d0..d7, stop.
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    logic       par;
  } vec_t;
  vec_t tv[10];

  int ncmp = 0;
  int nbad = 0;

  task automatic check(input string name, input logic act, input logic exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] d);
    CONECT_PRIZNAC = 1'b1;
    word_receiver  = d;
    @(negedge clk);
    CONECT_PRIZNAC = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_start();
    int n = 0;
    while (TX !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("frame_start", TX, 1'b0);
  endtask

  // Entry: at the first negedge showing the start bit. Exit: at the
  // negedge after the final stop tick (start of a chained frame, if any).
  task automatic check_frame(input int r, input int period, input bit more);
    logic eb[11];
    int   p;
    p = BT * period;
    eb[0] = tv[r].frame[0];
    for (int k = 0; k < 8; k++) eb[1+k] = tv[r].frame[1+k];
`ifdef UART_TX_PARITY_EN
    eb[9]  = tv[r].par;
    eb[10] = tv[r].frame[9];
`else
    eb[9]  = tv[r].frame[9];
    eb[10] = 1'b1;
`endif
    for (int b = 0; b < NBITS; b++) begin
      for (int c = 0; c < p; c++) begin
        check("tx_bit", TX, eb[b]);
        check("busy_in_frame", busy, 1'b1);
        if (b != 0 || c != 0) check("no_early_end", priznak_end_transmitter, 1'b0);
        @(negedge clk);
      end
    end
    check("end_pulse", priznak_end_transmitter, 1'b1);
    if (more) begin
      check("chained_start", TX, 1'b0);
      check("busy_chained", busy, 1'b1);
    end else begin
      check("tx_idle_after", TX, 1'b1);
      check("busy_drop", busy, 1'b0);
    end
  endtask

  initial begin
    tv[0] = '{8'hA5, 10'b1101001010, 1'b0};
    tv[1] = '{8'h00, 10'b1000000000, 1'b0};
    tv[2] = '{8'hFF, 10'b1111111110, 1'b0};
    tv[3] = '{8'h07, 10'b1000001110, 1'b1};
    tv[4] = '{8'h03, 10'b1000000110, 1'b0};
    tv[5] = '{8'h81, 10'b1100000010, 1'b0};
    tv[6] = '{8'h01, 10'b1000000010, 1'b1};
    tv[7] = '{8'h11, 10'b1000100010, 1'b0};
    tv[8] = '{8'h22, 10'b1001000100, 1'b0};
    tv[9] = '{8'h33, 10'b1001100110, 1'b0};

    // Reset state
    res = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", TX, 1'b1);
    check("rst_end", priznak_end_transmitter, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_full", fifo_full, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    res = 1'b0;

    // Single frames, ENABLE constant high
    en_period = 1;
    for (int r = 0; r < 7; r++) begin
      push(tv[r].data);
      wait_start();
      check_frame(r, 1, 1'b0);
      @(negedge clk);
      check("end_pulse_width", priznak_end_transmitter, 1'b0);
    end

    // Gapped tick: one ENABLE in three, 15 clk per bit
    en_period = 3;
    push(tv[1].data);
    wait_start();
    check_frame(1, 3, 1'b0);
    @(negedge clk);
    check("gap_pulse_width", priznak_end_transmitter, 1'b0);

    // Back-to-back frames
    en_period = 0;
    repeat (2) @(negedge clk);
    push(tv[7].data);
    push(tv[8].data);
    push(tv[9].data);
    en_period = 1;
    wait_start();
    check_frame(7, 1, 1'b1);
    check_frame(8, 1, 1'b1);
    check_frame(9, 1, 1'b0);

    // Overflow with line stalled
    en_period = 0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      push(tv[k].data);
      check("ovf_full", fifo_full, (k >= 3) ? 1'b1 : 1'b0);
      check("ovf_flag", overflow, (k >= 4) ? 1'b1 : 1'b0);
    end
    en_period = 1;
    wait_start();
    for (int k = 0; k < 4; k++) check_frame(k, 1, (k < 3) ? 1'b1 : 1'b0);
    for (int i = 0; i < 40; i++) begin
      check("no_fifth_frame", TX, 1'b1);
      @(negedge clk);
    end
    check("ovf_sticky", overflow, 1'b1);

    // Reset during data bit 3, with a second byte queued
    push(tv[0].data);
    wait_start();
    push(tv[2].data);
    repeat (20) @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    check("rst_mid_tx", TX, 1'b1);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_end", priznak_end_transmitter, 1'b0);
    check("rst_mid_ovf", overflow, 1'b0);
    res = 1'b0;
    for (int i = 0; i < 120; i++) begin
      check("rst_queue_empty_tx", TX, 1'b1);
      check("rst_no_end", priznak_end_transmitter, 1'b0);
      @(negedge clk);
    end
    push(tv[5].data);
    wait_start();
    check_frame(5, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
